kgp_run_ctrl: RTL and testbench



---
 rtl/kgp_run_pkg.sv | 15 +
 rtl/kgp_ce_div.sv | 38 +++
 rtl/kgp_run_ctrl.sv | 131 +++++++++++++
 tb/tb_kgp_run_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/kgp_run_pkg.sv
// Shared state encodings and parameter defaults for the KGPRISC run controller.
package kgp_run_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RESET_HOLD = 3'd1;
    localparam logic [2:0] ST_RUN        = 3'd2;
    localparam logic [2:0] ST_HALTED     = 3'd3;
    localparam logic [2:0] ST_TIMEOUT    = 3'd4;

    localparam int unsigned DEF_DIV        = 4;
    localparam int unsigned DEF_RST_CYCLES = 8;
    localparam int unsigned DEF_MAX_CYCLES = 100000;
    localparam int unsigned DEF_CNT_W      = 32;

endpackage

// File: rtl/kgp_ce_div.sv
// Clock-enable divider: one-cycle ce pulse every DIV enabled cycles, synchronous clear.
module kgp_ce_div #(
    parameter int unsigned DIV = kgp_run_pkg::DEF_DIV
) (
    input  logic clkf,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic ce
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             wrap_c;

    assign wrap_c = (div_q == DIV_W'(DIV - 1));
    assign ce     = en & wrap_c;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = wrap_c ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clkf or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/kgp_run_ctrl.sv
// Run controller for the KGPRISC CPU: timed reset release, clock enable,
// halt latching, executed-cycle counting and a watchdog timeout.
module kgp_run_ctrl
    import kgp_run_pkg::*;
#(
    parameter int unsigned DIV        = DEF_DIV,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clkf,
    input  logic             rst,
    input  logic             start_req,
    input  logic             cpu_stop,
    output logic             cpu_start,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [2:0]        state_q,     state_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              done_q,      done_d;
    logic              timeout_q,   timeout_d;
    logic              start_prev_q;
    logic              cpu_start_q, cpu_start_d;
    logic              busy_q,      busy_d;

    logic              start_edge_c;
    logic              run_c;
    logic              run_ce_c;
    logic [CNT_W-1:0]  cnt_inc_c;

    assign start_edge_c = start_req & ~start_prev_q;
    assign run_c        = (state_q == ST_RUN);
    assign cnt_inc_c    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Divider is held cleared outside RUN so every RUN entry starts at phase 0.
    kgp_ce_div #(
        .DIV (DIV)
    ) u_ce_div (
        .clkf (clkf),
        .rst  (rst),
        .clr  (~run_c),
        .en   (run_c),
        .ce   (run_ce_c)
    );

    assign cpu_ce = (state_q == ST_RESET_HOLD) | run_ce_c;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (start_edge_c) begin
                    state_d   = ST_RESET_HOLD;
                    hold_d    = HOLD_W'(RST_CYCLES - 1);
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RESET_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (run_ce_c) begin
                    cnt_d = cnt_inc_c;
                end
                // A halt on the same cycle as the watchdog limit counts as a normal halt.
                if (cpu_stop) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (run_ce_c && (cnt_inc_c == CNT_W'(MAX_CYCLES))) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cpu_start_d = (state_d == ST_RUN) || (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
        busy_d      = (state_d == ST_RESET_HOLD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clkf or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            start_prev_q <= 1'b0;
            cpu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            start_prev_q <= start_req;
            cpu_start_q  <= cpu_start_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_start   = cpu_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_kgp_run_ctrl.sv
// Directed self-checking bench for kgp_run_ctrl with DIV=4, RST_CYCLES=8, MAX_CYCLES=20.
module tb_kgp_run_ctrl;

    logic        clkf;
    logic        rst;
    logic        start_req;
    logic        cpu_stop;
    logic        cpu_start;
    logic        cpu_ce;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    kgp_run_ctrl #(
        .DIV        (4),
        .RST_CYCLES (8),
        .MAX_CYCLES (20),
        .CNT_W      (32)
    ) dut (
        .clkf        (clkf),
        .rst         (rst),
        .start_req   (start_req),
        .cpu_stop    (cpu_stop),
        .cpu_start   (cpu_start),
        .cpu_ce      (cpu_ce),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .state       (state)
    );

    initial clkf = 1'b0;
    always #5 clkf = ~clkf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clkf);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 32'(state), 0);
        chk({tag, ".cpu_start"}, 32'(cpu_start), 0);
        chk({tag, ".cpu_ce"}, 32'(cpu_ce), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".count"}, cycle_count, 0);
    endtask

    // Produce a clean rising edge; returns at the first RESET_HOLD cycle.
    task automatic do_start();
        start_req = 1'b0;
        step(1);
        start_req = 1'b1;
        step(1);
    endtask

    task automatic chk_hold();
        chk("hold.entry_done", 32'(done), 0);
        chk("hold.entry_timeout", 32'(timeout), 0);
        chk("hold.entry_count", cycle_count, 0);
        for (int i = 0; i < 8; i++) begin
            chk("hold.state", 32'(state), 1);
            chk("hold.cpu_ce", 32'(cpu_ce), 1);
            chk("hold.cpu_start", 32'(cpu_start), 0);
            chk("hold.busy", 32'(busy), 1);
            step(1);
        end
    endtask

    // RUN cycles k_from..k_to (1-based); raise cpu_stop during cycle stop_at.
    task automatic run_cycles(input int k_from, input int k_to, input int stop_at);
        for (int k = k_from; k <= k_to; k++) begin
            chk("run.state", 32'(state), 2);
            chk("run.cpu_start", 32'(cpu_start), 1);
            chk("run.cpu_ce", 32'(cpu_ce), 32'((k % 4) == 0));
            chk("run.count", cycle_count, 32'((k - 1) / 4));
            if (k == stop_at) cpu_stop = 1'b1;
            step(1);
        end
        cpu_stop = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start_req = 1'b0;
        cpu_stop  = 1'b0;
        step(3);
        chk_idle("in_reset");

        // Idle after reset with no request
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 10; i++) begin
            chk_idle("idle");
            chk("idle.done", 32'(done), 0);
            chk("idle.timeout", 32'(timeout), 0);
            step(1);
        end

        // Start, 8-cycle hold, run with a mid-RUN start toggle, halt on 6th pulse
        start_req = 1'b1;
        step(1);
        chk_hold();
        run_cycles(1, 10, 0);
        start_req = 1'b0;
        run_cycles(11, 11, 0);
        start_req = 1'b1;
        run_cycles(12, 24, 24);
        chk("halt.state", 32'(state), 3);
        chk("halt.done", 32'(done), 1);
        chk("halt.timeout", 32'(timeout), 0);
        chk("halt.count", cycle_count, 6);
        chk("halt.cpu_start", 32'(cpu_start), 1);
        chk("halt.busy", 32'(busy), 0);
        for (int i = 0; i < 50; i++) begin
            if (i == 10) cpu_stop = 1'b1;
            if (i == 20) cpu_stop = 1'b0;
            chk("halt.cpu_ce", 32'(cpu_ce), 0);
            chk("halt.count_frozen", cycle_count, 6);
            chk("halt.state_held", 32'(state), 3);
            step(1);
        end

        // Restart from HALTED, then watchdog timeout at 20 pulses
        do_start();
        chk_hold();
        run_cycles(1, 80, 0);
        chk("to.state", 32'(state), 4);
        chk("to.timeout", 32'(timeout), 1);
        chk("to.done", 32'(done), 0);
        chk("to.count", cycle_count, 20);
        chk("to.cpu_start", 32'(cpu_start), 1);
        for (int i = 0; i < 8; i++) begin
            chk("to.cpu_ce", 32'(cpu_ce), 0);
            chk("to.count_frozen", cycle_count, 20);
            step(1);
        end

        // Stop coinciding with the 20th pulse: halt wins
        do_start();
        chk_hold();
        run_cycles(1, 80, 80);
        chk("tie.state", 32'(state), 3);
        chk("tie.done", 32'(done), 1);
        chk("tie.timeout", 32'(timeout), 0);
        chk("tie.count", cycle_count, 20);

        // Asynchronous reset between pulses, then clean restart
        do_start();
        chk_hold();
        run_cycles(1, 5, 0);
        chk("pre_rst.count", cycle_count, 1);
        start_req = 1'b0;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        step(2);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk_idle("post_rst");
            step(1);
        end
        start_req = 1'b1;
        step(1);
        chk_hold();
        run_cycles(1, 8, 0);
        chk("restart.count", cycle_count, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
